// File: rtl/btb_pkg.sv
// Shared constants, types and helper functions for the branch target buffer.
// Defaults here are the standard build point (32-bit PC, 16 entries, 2-bit counters).
// Counter helpers are functions so that modules with non-default CTR_W can reuse them.
package btb_pkg;

   localparam int BTB_XLEN  = 32;
   localparam int BTB_DEPTH = 16;
   localparam int BTB_CTR_W = 2;

   localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
   localparam int BTB_TAG_W = BTB_XLEN - BTB_IDX_W - 2;

   typedef logic [BTB_CTR_W-1:0] btb_ctr_t;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [BTB_XLEN-1:0]  target;
      btb_ctr_t             ctr;
   } btb_entry_t;

   // Saturation ceiling of a w-bit counter: 2^w - 1.
   function automatic longint unsigned ctr_max(int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Weakly-taken value of a w-bit counter: MSB set, all other bits clear.
   function automatic longint unsigned ctr_weak_taken(int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

   localparam btb_ctr_t CTR_MAX        = BTB_CTR_W'(ctr_max(BTB_CTR_W));
   localparam btb_ctr_t CTR_WEAK_TAKEN = BTB_CTR_W'(ctr_weak_taken(BTB_CTR_W));

endpackage

// File: rtl/btb_sat_counter.sv
// Purpose: next value of a CTR_W-bit saturating predictor counter given the resolved outcome.
// Latency: combinational. Backpressure: none.
// Ports: ctr_i current count, taken_i outcome (1 = count up), ctr_o next count.
module btb_sat_counter
   import btb_pkg::*;
#(
   parameter int CTR_W = BTB_CTR_W
)(
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] ctr_o
);

   localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != MAX) ctr_o = ctr_i + 1'b1;
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Purpose: direct-mapped branch target buffer; fetch looks up by PC, execute writes back resolved branches.
// Latency: lookup response (resp_valid/hit/pred_taken/pred_target) registered, one cycle after btb_lookup_en.
// Backpressure: none; a lookup and an update may be accepted every cycle.
// Ports: btb_clk/btb_rst_n (sync, active-low); btb_lookup_en/pc in, btb_resp_valid/hit/pred_taken/pred_target out;
//        btb_update_en/pc/branch_taken/branch_target in. Define BTB_PERF_EN to add 32-bit
//        btb_perf_lookups/hits/mispredicts outputs.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int XLEN  = BTB_XLEN,
   parameter int DEPTH = BTB_DEPTH,
   parameter int CTR_W = BTB_CTR_W
)(
   input  logic            btb_clk,
   input  logic            btb_rst_n,
   input  logic            btb_lookup_en,
   input  logic [XLEN-1:0] btb_lookup_pc,
   output logic            btb_resp_valid,
   output logic            btb_hit,
   output logic            btb_pred_taken,
   output logic [XLEN-1:0] btb_pred_target,
`ifdef BTB_PERF_EN
   output logic [31:0]     btb_perf_lookups,
   output logic [31:0]     btb_perf_hits,
   output logic [31:0]     btb_perf_mispredicts,
`endif
   input  logic            btb_update_en,
   input  logic [XLEN-1:0] btb_update_pc,
   input  logic            btb_branch_taken,
   input  logic [XLEN-1:0] btb_branch_target
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_taken(CTR_W));

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic [CTR_W-1:0] ctr;
   } entry_t;

   entry_t entry_q [DEPTH];

   // Instructions are word aligned; the low PC bits carry no information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

   // ---------------- lookup path ----------------
   logic [IDX_W-1:0] lu_idx;
   logic [TAG_W-1:0] lu_tag;
   logic             lu_hit;

   assign lu_idx = btb_lookup_pc[IDX_W+1:2];
   assign lu_tag = btb_lookup_pc[XLEN-1:IDX_W+2];
   // Reads entry_q before this edge's write, so a same-cycle update is not visible.
   assign lu_hit = btb_lookup_en && entry_q[lu_idx].valid && (entry_q[lu_idx].tag == lu_tag);

   logic            resp_valid_q, resp_valid_d;
   logic            hit_q, hit_d;
   logic            taken_q, taken_d;
   logic [XLEN-1:0] target_q, target_d;

   always_comb begin
      resp_valid_d = btb_lookup_en;
      hit_d        = lu_hit;
      taken_d      = lu_hit && entry_q[lu_idx].ctr[CTR_W-1];
      target_d     = lu_hit ? entry_q[lu_idx].target : '0;
   end

   always_ff @(posedge btb_clk) begin
      if (!btb_rst_n) begin
         resp_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         taken_q      <= 1'b0;
         target_q     <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         hit_q        <= hit_d;
         taken_q      <= taken_d;
         target_q     <= target_d;
      end
   end

   assign btb_resp_valid  = resp_valid_q;
   assign btb_hit         = hit_q;
   assign btb_pred_taken  = taken_q;
   assign btb_pred_target = target_q;

   // ---------------- update path ----------------
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [CTR_W-1:0] up_ctr_next;
   logic             upd_we;
   entry_t           upd_entry_d;

   assign up_idx = btb_update_pc[IDX_W+1:2];
   assign up_tag = btb_update_pc[XLEN-1:IDX_W+2];
   assign up_hit = entry_q[up_idx].valid && (entry_q[up_idx].tag == up_tag);

   btb_sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
      .ctr_i   (entry_q[up_idx].ctr),
      .taken_i (btb_branch_taken),
      .ctr_o   (up_ctr_next)
   );

   always_comb begin
      upd_we      = 1'b0;
      upd_entry_d = entry_q[up_idx];
      if (btb_update_en) begin
         if (up_hit) begin
            upd_we          = 1'b1;
            upd_entry_d.ctr = up_ctr_next;
            if (btb_branch_taken) upd_entry_d.target = btb_branch_target;
         end else if (btb_branch_taken) begin
            // Miss on a taken branch evicts whatever aliased into this slot.
            upd_we             = 1'b1;
            upd_entry_d.valid  = 1'b1;
            upd_entry_d.tag    = up_tag;
            upd_entry_d.target = btb_branch_target;
            upd_entry_d.ctr    = CTR_INIT;
         end
      end
   end

   // Only valid bits are reset; tag/target/ctr are qualified by valid.
   always_ff @(posedge btb_clk) begin
      if (!btb_rst_n) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i].valid <= 1'b0;
      end else if (upd_we) begin
         entry_q[up_idx] <= upd_entry_d;
      end
   end

`ifdef BTB_PERF_EN
   // ---------------- performance counters ----------------
   logic            pred_dir;
   logic [XLEN-1:0] pred_tgt;
   logic            mispredict;
   logic [31:0]     perf_lookups_q, perf_lookups_d;
   logic [31:0]     perf_hits_q, perf_hits_d;
   logic [31:0]     perf_mispred_q, perf_mispred_d;

   // What the buffer would have predicted for the branch being resolved.
   assign pred_dir   = up_hit && entry_q[up_idx].ctr[CTR_W-1];
   assign pred_tgt   = up_hit ? entry_q[up_idx].target : '0;
   assign mispredict = btb_update_en &&
                       ((pred_dir != btb_branch_taken) ||
                        (btb_branch_taken && (pred_tgt != btb_branch_target)));

   always_comb begin
      perf_lookups_d = perf_lookups_q + {31'd0, resp_valid_q};
      perf_hits_d    = perf_hits_q + {31'd0, resp_valid_q && hit_q};
      perf_mispred_d = perf_mispred_q + {31'd0, mispredict};
   end

   always_ff @(posedge btb_clk) begin
      if (!btb_rst_n) begin
         perf_lookups_q <= '0;
         perf_hits_q    <= '0;
         perf_mispred_q <= '0;
      end else begin
         perf_lookups_q <= perf_lookups_d;
         perf_hits_q    <= perf_hits_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   assign btb_perf_lookups     = perf_lookups_q;
   assign btb_perf_hits        = perf_hits_q;
   assign btb_perf_mispredicts = perf_mispred_q;
`endif

endmodule
